// File: rtl/cnn_accel_ahb_regs_pkg.sv
// CNN accelerator register map shared by the AHB register block and software headers.
// Holds byte offsets, word indices used for decode, and LAYER_CONFIG field positions.
package cnn_accel_ahb_regs_pkg;

    // Byte offsets of the register map
    localparam logic [7:0] OFS_FRAME_SIZE   = 8'h00;
    localparam logic [7:0] OFS_WIDTH_HEIGHT = 8'h04;
    localparam logic [7:0] OFS_DELAY_PARAMS = 8'h08;
    localparam logic [7:0] OFS_BASE_ADDRESS = 8'h0C;
    localparam logic [7:0] OFS_LAYER_CONFIG = 8'h10;
    localparam logic [7:0] OFS_LAYER_START  = 8'h14;
    localparam logic [7:0] OFS_LAYER_DONE   = 8'h18;

    localparam int unsigned IDX_W = 6;

    // Word index (HADDR[7:2]) of a byte offset
    function automatic logic [IDX_W-1:0] word_idx(input logic [7:0] ofs);
        return ofs[7:2];
    endfunction

    localparam logic [IDX_W-1:0] IDX_FRAME_SIZE   = word_idx(OFS_FRAME_SIZE);
    localparam logic [IDX_W-1:0] IDX_WIDTH_HEIGHT = word_idx(OFS_WIDTH_HEIGHT);
    localparam logic [IDX_W-1:0] IDX_DELAY_PARAMS = word_idx(OFS_DELAY_PARAMS);
    localparam logic [IDX_W-1:0] IDX_BASE_ADDRESS = word_idx(OFS_BASE_ADDRESS);
    localparam logic [IDX_W-1:0] IDX_LAYER_CONFIG = word_idx(OFS_LAYER_CONFIG);
    localparam logic [IDX_W-1:0] IDX_LAYER_START  = word_idx(OFS_LAYER_START);
    localparam logic [IDX_W-1:0] IDX_LAYER_DONE   = word_idx(OFS_LAYER_DONE);

    // LAYER_CONFIG field positions (bits above CFG_W read as zero)
    localparam int unsigned CFG_W          = 16;
    localparam int unsigned CFG_IS_FIRST   = 0;
    localparam int unsigned CFG_IS_LAST    = 1;
    localparam int unsigned CFG_IS_CONV3X3 = 2;
    localparam int unsigned CFG_RESERVED   = 3;
    localparam int unsigned CFG_INDEX_LSB  = 4;
    localparam int unsigned CFG_INDEX_W    = 4;
    localparam int unsigned CFG_BIAS_LSB   = 8;
    localparam int unsigned CFG_BIAS_W     = 5;
    localparam int unsigned CFG_ACT_LSB    = 13;
    localparam int unsigned CFG_ACT_W      = 3;

    // AHB response encoding
    localparam logic [1:0] HRESP_OKAY = 2'b00;

endpackage

// File: rtl/cnn_accel_ahb_regs.sv
// AHB-Lite slave register block for the CNN accelerator.
// Zero-wait-state, always-OKAY slave. Address phase is registered; writes take
// HWDATA in the following cycle and reads return current contents in the data phase.
// Ports:
//   HCLK, HRESET          - clock, asynchronous active-high reset
//   sl_H*                 - AHB slave inputs (HSIZE/HBURST ignored, 32-bit accesses)
//   out_sl_H*             - AHB slave outputs
//   i_layer_done          - single-cycle completion pulse from the compute engine
//   o_* config            - frame geometry, delays and base addresses
//   o_* layer             - layer configuration fields, start level and start pulse
module cnn_accel_ahb_regs
    import cnn_accel_ahb_regs_pkg::*;
#(
    parameter int unsigned W_ADDR = 32,
    parameter int unsigned W_DATA = 32
) (
    input  logic              HCLK,
    input  logic              HRESET,
    input  logic              sl_HSEL,
    input  logic              sl_HREADY,
    input  logic [1:0]        sl_HTRANS,
    input  logic [2:0]        sl_HBURST,
    input  logic [2:0]        sl_HSIZE,
    input  logic [W_ADDR-1:0] sl_HADDR,
    input  logic              sl_HWRITE,
    input  logic [W_DATA-1:0] sl_HWDATA,
    output logic              out_sl_HREADY,
    output logic [1:0]        out_sl_HRESP,
    output logic [W_DATA-1:0] out_sl_HRDATA,
    input  logic              i_layer_done,
    output logic [24:0]       o_frame_size,
    output logic [11:0]       o_width,
    output logic [11:0]       o_height,
    output logic [11:0]       o_start_up_delay,
    output logic [11:0]       o_hsync_delay,
    output logic [19:0]       o_base_addr_weight,
    output logic [11:0]       o_base_addr_param,
    output logic              o_is_first_layer,
    output logic              o_is_last_layer,
    output logic              o_is_conv3x3,
    output logic [3:0]        o_layer_index,
    output logic [4:0]        o_bias_shift,
    output logic [2:0]        o_act_shift,
    output logic              o_layer_start,
    output logic              o_layer_start_pulse
);

    // Pending address-phase state
    logic             valid_q, valid_d;
    logic             write_q, write_d;
    logic [IDX_W-1:0] addr_q, addr_d;

    // Register contents
    logic [24:0]      frame_size_q, frame_size_d;
    logic [11:0]      width_q, width_d;
    logic [11:0]      height_q, height_d;
    logic [11:0]      startup_q, startup_d;
    logic [11:0]      hsync_q, hsync_d;
    logic [19:0]      weight_q, weight_d;
    logic [11:0]      param_q, param_d;
    logic [CFG_W-1:0] layer_cfg_q, layer_cfg_d;
    logic             start_q, start_d;
    logic             pulse_q, pulse_d;
    logic             done_q, done_d;

    logic        accept;
    logic        wr_en;
    logic [31:0] wdata;
    logic [31:0] rdata;

    assign accept = sl_HSEL & sl_HREADY & sl_HTRANS[1];
    assign wr_en  = valid_q & write_q;
    assign wdata  = sl_HWDATA[31:0];

    always_comb begin
        valid_d      = accept;
        write_d      = write_q;
        addr_d       = addr_q;
        frame_size_d = frame_size_q;
        width_d      = width_q;
        height_d     = height_q;
        startup_d    = startup_q;
        hsync_d      = hsync_q;
        weight_d     = weight_q;
        param_d      = param_q;
        layer_cfg_d  = layer_cfg_q;
        start_d      = start_q;
        pulse_d      = 1'b0;

        if (accept) begin
            write_d = sl_HWRITE;
            addr_d  = sl_HADDR[7:2];
        end

        if (wr_en) begin
            case (addr_q)
                IDX_FRAME_SIZE:   frame_size_d = wdata[24:0];
                IDX_WIDTH_HEIGHT: begin
                    width_d  = wdata[11:0];
                    height_d = wdata[27:16];
                end
                IDX_DELAY_PARAMS: begin
                    startup_d = wdata[11:0];
                    hsync_d   = wdata[23:12];
                end
                IDX_BASE_ADDRESS: begin
                    weight_d = wdata[19:0];
                    param_d  = wdata[31:20];
                end
                IDX_LAYER_CONFIG: layer_cfg_d = wdata[CFG_W-1:0];
                IDX_LAYER_START: begin
                    start_d = wdata[0];
                    // Only a 0->1 transition launches a layer
                    pulse_d = wdata[0] & ~start_q;
                end
                default: ;
            endcase
        end

        // Launching a new layer clears the sticky done flag, winning over a new done
        if (pulse_q) begin
            done_d = 1'b0;
        end else if (i_layer_done) begin
            done_d = 1'b1;
        end else begin
            done_d = done_q;
        end
    end

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            valid_q      <= 1'b0;
            write_q      <= 1'b0;
            addr_q       <= '0;
            frame_size_q <= '0;
            width_q      <= '0;
            height_q     <= '0;
            startup_q    <= '0;
            hsync_q      <= '0;
            weight_q     <= '0;
            param_q      <= '0;
            layer_cfg_q  <= '0;
            start_q      <= 1'b0;
            pulse_q      <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            valid_q      <= valid_d;
            write_q      <= write_d;
            addr_q       <= addr_d;
            frame_size_q <= frame_size_d;
            width_q      <= width_d;
            height_q     <= height_d;
            startup_q    <= startup_d;
            hsync_q      <= hsync_d;
            weight_q     <= weight_d;
            param_q      <= param_d;
            layer_cfg_q  <= layer_cfg_d;
            start_q      <= start_d;
            pulse_q      <= pulse_d;
            done_q       <= done_d;
        end
    end

    // Read mux; a write data phase has already committed by the time a
    // following read reaches its data phase, so no bypass is needed.
    always_comb begin
        rdata = '0;
        if (valid_q && !write_q) begin
            case (addr_q)
                IDX_FRAME_SIZE:   rdata[24:0] = frame_size_q;
                IDX_WIDTH_HEIGHT: begin
                    rdata[11:0]  = width_q;
                    rdata[27:16] = height_q;
                end
                IDX_DELAY_PARAMS: begin
                    rdata[11:0]  = startup_q;
                    rdata[23:12] = hsync_q;
                end
                IDX_BASE_ADDRESS: begin
                    rdata[19:0]  = weight_q;
                    rdata[31:20] = param_q;
                end
                IDX_LAYER_CONFIG: rdata[CFG_W-1:0] = layer_cfg_q;
                IDX_LAYER_START:  rdata[0] = start_q;
                IDX_LAYER_DONE:   rdata[0] = done_q;
                default: ;
            endcase
        end
    end

    assign out_sl_HREADY = 1'b1;
    assign out_sl_HRESP  = HRESP_OKAY;
    assign out_sl_HRDATA = W_DATA'(rdata);

    assign o_frame_size       = frame_size_q;
    assign o_width            = width_q;
    assign o_height           = height_q;
    assign o_start_up_delay   = startup_q;
    assign o_hsync_delay      = hsync_q;
    assign o_base_addr_weight = weight_q;
    assign o_base_addr_param  = param_q;

    assign o_is_first_layer = layer_cfg_q[CFG_IS_FIRST];
    assign o_is_last_layer  = layer_cfg_q[CFG_IS_LAST];
    assign o_is_conv3x3     = layer_cfg_q[CFG_IS_CONV3X3];
    assign o_layer_index    = layer_cfg_q[CFG_INDEX_LSB +: CFG_INDEX_W];
    assign o_bias_shift     = layer_cfg_q[CFG_BIAS_LSB +: CFG_BIAS_W];
    assign o_act_shift      = layer_cfg_q[CFG_ACT_LSB +: CFG_ACT_W];

    assign o_layer_start       = start_q;
    assign o_layer_start_pulse = pulse_q;

    // Inputs that carry no meaning for this slave; reserved config bit is store-only
    logic unused_bits;
    assign unused_bits = ^{sl_HBURST, sl_HSIZE, sl_HTRANS[0], sl_HADDR[W_ADDR-1:8],
                           sl_HADDR[1:0], layer_cfg_q[CFG_RESERVED]};

endmodule

// File: tb/tb_cnn_accel_ahb_regs.sv
module tb_cnn_accel_ahb_regs;

    localparam logic [1:0] K_IDLE = 2'd0;
    localparam logic [1:0] K_WR   = 2'd1;
    localparam logic [1:0] K_RD   = 2'd2;
    localparam logic [1:0] K_BUSY = 2'd3;

    typedef struct packed {
        logic [1:0]  kind;
        logic [7:0]  addr;
        logic [31:0] data;   // write data, or expected read data
    } vec_t;

    logic        HCLK = 1'b0;
    logic        HRESET;
    logic        sl_HSEL, sl_HREADY, sl_HWRITE;
    logic [1:0]  sl_HTRANS;
    logic [2:0]  sl_HBURST, sl_HSIZE;
    logic [31:0] sl_HADDR, sl_HWDATA;
    logic        out_sl_HREADY;
    logic [1:0]  out_sl_HRESP;
    logic [31:0] out_sl_HRDATA;
    logic        i_layer_done;
    logic [24:0] o_frame_size;
    logic [11:0] o_width, o_height, o_start_up_delay, o_hsync_delay, o_base_addr_param;
    logic [19:0] o_base_addr_weight;
    logic        o_is_first_layer, o_is_last_layer, o_is_conv3x3;
    logic [3:0]  o_layer_index;
    logic [4:0]  o_bias_shift;
    logic [2:0]  o_act_shift;
    logic        o_layer_start, o_layer_start_pulse;

    int n_cmp = 0;
    int n_err = 0;

    always #5 HCLK = ~HCLK;

    cnn_accel_ahb_regs #(.W_ADDR(32), .W_DATA(32)) dut (
        .HCLK(HCLK), .HRESET(HRESET),
        .sl_HSEL(sl_HSEL), .sl_HREADY(sl_HREADY), .sl_HTRANS(sl_HTRANS),
        .sl_HBURST(sl_HBURST), .sl_HSIZE(sl_HSIZE), .sl_HADDR(sl_HADDR),
        .sl_HWRITE(sl_HWRITE), .sl_HWDATA(sl_HWDATA),
        .out_sl_HREADY(out_sl_HREADY), .out_sl_HRESP(out_sl_HRESP),
        .out_sl_HRDATA(out_sl_HRDATA), .i_layer_done(i_layer_done),
        .o_frame_size(o_frame_size), .o_width(o_width), .o_height(o_height),
        .o_start_up_delay(o_start_up_delay), .o_hsync_delay(o_hsync_delay),
        .o_base_addr_weight(o_base_addr_weight), .o_base_addr_param(o_base_addr_param),
        .o_is_first_layer(o_is_first_layer), .o_is_last_layer(o_is_last_layer),
        .o_is_conv3x3(o_is_conv3x3), .o_layer_index(o_layer_index),
        .o_bias_shift(o_bias_shift), .o_act_shift(o_act_shift),
        .o_layer_start(o_layer_start), .o_layer_start_pulse(o_layer_start_pulse)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // One bus cycle: address phase of a, data phase of p. Called #1 after a rising edge.
    task automatic do_cycle(input vec_t a, input vec_t p);
        sl_HSEL   = (a.kind != K_IDLE);
        sl_HTRANS = (a.kind == K_WR || a.kind == K_RD) ? 2'b10 :
                    (a.kind == K_BUSY) ? 2'b01 : 2'b00;
        sl_HWRITE = (a.kind == K_WR || a.kind == K_BUSY);
        sl_HADDR  = {24'h0, a.addr};
        sl_HWDATA = (p.kind == K_WR) ? p.data : 32'hDEAD_BEEF;
        @(negedge HCLK);
        chk("hready", {31'b0, out_sl_HREADY}, 32'd1);
        chk("hresp", {30'b0, out_sl_HRESP}, 32'd0);
        if (p.kind == K_RD) chk($sformatf("read_0x%02h", p.addr), out_sl_HRDATA, p.data);
        @(posedge HCLK);
        #1;
    endtask

    localparam vec_t IDLE = '{K_IDLE, 8'h00, 32'h0};

    task automatic wr(input logic [7:0] addr, input logic [31:0] data);
        vec_t v;
        v = '{K_WR, addr, data};
        do_cycle(v, IDLE);
        do_cycle(IDLE, v);
    endtask

    task automatic rd(input logic [7:0] addr, input logic [31:0] exp);
        vec_t v;
        v = '{K_RD, addr, exp};
        do_cycle(v, IDLE);
        do_cycle(IDLE, v);
    endtask

    task automatic pulse_done();
        i_layer_done = 1'b1;
        @(posedge HCLK);
        #1;
        i_layer_done = 1'b0;
    endtask

    vec_t tbl[$];
    vec_t prev;

    initial begin
        HRESET = 1'b1;
        sl_HSEL = 0; sl_HREADY = 1; sl_HTRANS = 0; sl_HBURST = 0; sl_HSIZE = 3'b010;
        sl_HADDR = 0; sl_HWRITE = 0; sl_HWDATA = 0; i_layer_done = 0;

        // Reset state
        repeat (2) @(posedge HCLK);
        @(negedge HCLK);
        chk("rst_hready", {31'b0, out_sl_HREADY}, 32'd1);
        chk("rst_hresp", {30'b0, out_sl_HRESP}, 32'd0);
        chk("rst_hrdata", out_sl_HRDATA, 32'd0);
        chk("rst_frame", {7'b0, o_frame_size}, 32'd0);
        chk("rst_cfg", {o_is_first_layer, o_is_last_layer, o_is_conv3x3, o_layer_index,
                        o_bias_shift, o_act_shift, o_layer_start, o_layer_start_pulse}, 32'd0);
        @(posedge HCLK);
        #1;
        HRESET = 1'b0;

        // Pipelined table: entry i is in address phase while entry i-1 is in data phase
        tbl.push_back('{K_WR, 8'h10, 32'hFFFF_FFFF});
        tbl.push_back('{K_RD, 8'h10, 32'h0000_FFFF});
        tbl.push_back('{K_WR, 8'h04, 32'hFFFF_FFFF});
        tbl.push_back('{K_RD, 8'h04, 32'h0FFF_0FFF});
        tbl.push_back('{K_WR, 8'h08, 32'hFFFF_FFFF});
        tbl.push_back('{K_RD, 8'h08, 32'h00FF_FFFF});
        tbl.push_back('{K_WR, 8'h0C, 32'hFFFF_FFFF});
        tbl.push_back('{K_RD, 8'h0C, 32'hFFFF_FFFF});
        tbl.push_back('{K_WR, 8'h00, 32'hFFFF_FFFF});
        tbl.push_back('{K_RD, 8'h00, 32'h01FF_FFFF});
        tbl.push_back('{K_WR, 8'h00, 32'd16384});
        tbl.push_back('{K_WR, 8'h04, 32'h0080_0080});
        tbl.push_back('{K_WR, 8'h08, 32'h000A_00C8});
        tbl.push_back(IDLE);
        tbl.push_back('{K_RD, 8'h00, 32'd16384});
        tbl.push_back('{K_RD, 8'h04, 32'h0080_0080});
        tbl.push_back('{K_RD, 8'h08, 32'h000A_00C8});
        tbl.push_back('{K_BUSY, 8'h00, 32'h0});
        tbl.push_back('{K_RD, 8'h00, 32'd16384});
        tbl.push_back('{K_WR, 8'h10, 32'h0000_F114});
        tbl.push_back('{K_RD, 8'h10, 32'h0000_F114});
        tbl.push_back('{K_WR, 8'h0C, 32'h0100_0010});
        tbl.push_back('{K_RD, 8'h0C, 32'h0100_0010});
        tbl.push_back('{K_RD, 8'h3C, 32'h0});
        tbl.push_back('{K_WR, 8'h3C, 32'hFFFF_FFFF});
        tbl.push_back('{K_RD, 8'h3C, 32'h0});
        tbl.push_back('{K_WR, 8'h18, 32'hFFFF_FFFF});
        tbl.push_back('{K_RD, 8'h18, 32'h0});
        tbl.push_back('{K_RD, 8'h14, 32'h0});

        prev = IDLE;
        foreach (tbl[i]) begin
            do_cycle(tbl[i], prev);
            prev = tbl[i];
        end
        do_cycle(IDLE, prev);

        chk("o_frame_size", {7'b0, o_frame_size}, 32'd16384);
        chk("o_width", {20'b0, o_width}, 32'd128);
        chk("o_height", {20'b0, o_height}, 32'd128);
        chk("o_start_up_delay", {20'b0, o_start_up_delay}, 32'd200);
        chk("o_hsync_delay", {20'b0, o_hsync_delay}, 32'd160);
        chk("o_base_addr_weight", {12'b0, o_base_addr_weight}, 32'h10);
        chk("o_base_addr_param", {20'b0, o_base_addr_param}, 32'h10);
        chk("o_act_shift", {29'b0, o_act_shift}, 32'd7);
        chk("o_bias_shift", {27'b0, o_bias_shift}, 32'd17);
        chk("o_layer_index", {28'b0, o_layer_index}, 32'd1);
        chk("o_flags", {29'b0, o_is_first_layer, o_is_last_layer, o_is_conv3x3}, 32'd1);

        // Start pulse: one cycle on 0->1 only
        wr(8'h14, 32'h1);
        chk("start_pulse_on", {31'b0, o_layer_start_pulse}, 32'd1);
        chk("start_level_on", {31'b0, o_layer_start}, 32'd1);
        do_cycle(IDLE, IDLE);
        chk("start_pulse_once", {31'b0, o_layer_start_pulse}, 32'd0);
        wr(8'h14, 32'h1);
        chk("start_no_retrigger", {31'b0, o_layer_start_pulse}, 32'd0);
        wr(8'h14, 32'h0);
        chk("start_level_off", {31'b0, o_layer_start}, 32'd0);
        chk("start_pulse_off", {31'b0, o_layer_start_pulse}, 32'd0);
        rd(8'h14, 32'h0);

        // Sticky done, cleared by the next start
        pulse_done();
        rd(8'h18, 32'h1);
        wr(8'h18, 32'h0);
        rd(8'h18, 32'h1);
        wr(8'h14, 32'h1);
        chk("start_pulse_2", {31'b0, o_layer_start_pulse}, 32'd1);
        do_cycle(IDLE, IDLE);
        rd(8'h18, 32'h0);

        // Done coinciding with the start pulse: clear wins
        pulse_done();
        rd(8'h18, 32'h1);
        wr(8'h14, 32'h0);
        rd(8'h18, 32'h1);
        wr(8'h14, 32'h1);
        chk("start_pulse_3", {31'b0, o_layer_start_pulse}, 32'd1);
        pulse_done();
        rd(8'h18, 32'h0);
        wr(8'h18, 32'hFFFF_FFFF);
        rd(8'h18, 32'h0);

        // Reset during a write data phase
        do_cycle('{K_WR, 8'h00, 32'h0000_1234}, IDLE);
        sl_HSEL = 0; sl_HTRANS = 0; sl_HWDATA = 32'h0000_1234;
        HRESET = 1'b1;
        #1;
        chk("rst_async_frame", {7'b0, o_frame_size}, 32'd0);
        chk("rst_async_width", {20'b0, o_width}, 32'd0);
        chk("rst_async_start", {31'b0, o_layer_start}, 32'd0);
        chk("rst_async_cfg", {24'b0, o_act_shift, o_bias_shift}, 32'd0);
        chk("rst_async_hready", {31'b0, out_sl_HREADY}, 32'd1);
        @(posedge HCLK);
        #1;
        HRESET = 1'b0;
        chk("rst_frame_not_kept", {7'b0, o_frame_size}, 32'd0);
        rd(8'h00, 32'h0);
        wr(8'h00, 32'd5);
        chk("post_rst_frame", {7'b0, o_frame_size}, 32'd5);
        rd(8'h00, 32'd5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/cnn_accel_ahb_regs.md
CNN_ACCEL_AHB_REGS -- requirements
Module: cnn_accel_ahb_regs

Interface
REQ-001 SHALL have parameter W_ADDR, default 32, meaning AHB address width.
REQ-002 SHALL have parameter W_DATA, default 32, meaning AHB data width.
REQ-003 SHALL have ports: HCLK  in  1  single clock, all logic on its rising edge.
REQ-004 SHALL have ports: HRESET  in  1  asynchronous, active-high reset.
REQ-005 SHALL have AHB slave inputs: sl_HSEL 1, sl_HREADY 1, sl_HTRANS 2, sl_HBURST 3, sl_HSIZE 3, sl_HADDR W_ADDR, sl_HWRITE 1, sl_HWDATA W_DATA.
REQ-006 SHALL have AHB slave outputs: out_sl_HREADY 1, out_sl_HRESP 2, out_sl_HRDATA W_DATA.
REQ-007 SHALL have core-side input i_layer_done (1), a one-cycle pulse from the compute engine.
REQ-008 SHALL have config outputs: o_frame_size 25, o_width 12, o_height 12, o_start_up_delay 12, o_hsync_delay 12, o_base_addr_weight 20, o_base_addr_param 12.
REQ-009 SHALL have layer outputs: o_is_first_layer 1, o_is_last_layer 1, o_is_conv3x3 1, o_layer_index 4, o_bias_shift 5, o_act_shift 3, o_layer_start 1 (level), o_layer_start_pulse 1.

Function
REQ-010 SHALL accept a transfer when sl_HSEL=1, sl_HREADY=1, sl_HTRANS[1]=1 (NONSEQ/SEQ); IDLE/BUSY ignored.
REQ-011 SHALL register address and HWRITE in the address phase; write uses sl_HWDATA in the following (data-phase) cycle.
REQ-012 SHALL decode sl_HADDR[7:2]: 0x00 FRAME_SIZE, 0x04 WIDTH_HEIGHT, 0x08 DELAY_PARAMS, 0x0C BASE_ADDRESS, 0x10 LAYER_CONFIG, 0x14 LAYER_START, 0x18 LAYER_DONE (read-only).
REQ-013 SHALL map fields: FRAME_SIZE[24:0]; WIDTH_HEIGHT width=[11:0], height=[27:16]; DELAY_PARAMS startup=[11:0], hsync=[23:12]; BASE_ADDRESS weight=[19:0], param=[31:20].
REQ-014 SHALL map LAYER_CONFIG: [0] is_first, [1] is_last, [2] is_conv3x3, [3] reserved (stored, read back), [7:4] layer_index, [12:8] bias_shift, [15:13] act_shift; bits [31:16] read 0.
REQ-015 SHALL always drive out_sl_HREADY=1 (zero wait states) and out_sl_HRESP=2'b00 (OKAY); sl_HSIZE/sl_HBURST ignored, all accesses treated as 32-bit.
REQ-016 SHALL return read data in the data phase from current register contents; unwritten bits and unmapped offsets read 0.
REQ-017 SHALL ignore writes to LAYER_DONE and unmapped offsets with no side effect.
REQ-018 SHALL hold o_layer_start = LAYER_START[0]; o_layer_start_pulse high exactly one cycle after a data-phase write changing bit0 from 0 to 1.
REQ-019 SHALL set sticky LAYER_DONE[0] on i_layer_done; clear it on the cycle o_layer_start_pulse asserts.
REQ-020 SHALL give the clear priority when clear and i_layer_done coincide.
REQ-021 SHALL make a write visible to a read whose address phase coincides with the write data phase (back-to-back write->read to same offset returns new value).
REQ-022 SHALL update config outputs one cycle after the write data phase and hold them until rewritten.

Reset
REQ-023 SHALL asynchronously clear every register, pending address-phase state, and output to 0 when HRESET=1, except out_sl_HREADY=1 and out_sl_HRESP=OKAY.
REQ-024 SHALL discard a transfer in flight when reset asserts; first post-reset transfer behaves normally.

Structure
REQ-025 SHALL take register offsets and LAYER_CONFIG field positions from the shared CNN-accelerator map header/package, not local literals.
REQ-026 SHALL be a single module; no sub-module needed.

Verification
REQ-027 Write FRAME_SIZE=16384, WIDTH_HEIGHT=0x00800080, DELAY_PARAMS=0x0A00C8 -> o_frame_size=16384, o_width=o_height=128, o_start_up_delay=200, o_hsync_delay=160; reads return same.
REQ-028 Write LAYER_CONFIG with act=7, bias=17, index=1, conv3x3=1, first=0, last=0 -> o_act_shift=7, o_bias_shift=17, o_layer_index=1, o_is_conv3x3=1; readback 0x0000F114.
REQ-029 Write LAYER_START=1 then 0 -> one o_layer_start_pulse; pulse i_layer_done -> LAYER_DONE reads 1; next LAYER_START=1 -> reads 0.
REQ-030 i_layer_done on same cycle as start pulse -> LAYER_DONE stays 0; write to 0x18 -> no change.
REQ-031 Back-to-back write BASE_ADDRESS=0x0100_0010 then read same offset -> 0x01000010; read 0x3C -> 0; HREADY always 1, HRESP always 0.
REQ-032 Assert HRESET during write data phase -> all outputs 0 immediately, written value not retained.
